// File: rtl/issue_rat_freelist_alloc_arbiter.sv
// Prefetches free PRF indices from the RAT free-list into a small circular buffer,
// hands them out round-robin to rename lanes, and returns unused entries on flush.
module issue_rat_freelist_alloc_arbiter #(
    parameter int PRF_WIDTH = 6,
    parameter int REQ_COUNT = 2,
    parameter int BUF_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [REQ_COUNT-1:0] i_req_valid,
    output logic [REQ_COUNT-1:0] o_alloc_valid,
    output logic [PRF_WIDTH-1:0] o_alloc_prf,
    input  logic [PRF_WIDTH-1:0] i_fifo_prf,
    input  logic                 i_fifo_valid,
    output logic                 o_fifo_ready,
    output logic [PRF_WIDTH-1:0] o_return_prf,
    output logic                 o_return_valid,
    input  logic                 i_return_ready,
    input  logic                 i_flush,
    output logic                 o_busy
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int RR_W  = $clog2(REQ_COUNT);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

    typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

    state_t                 state, state_next;
    logic [PRF_WIDTH-1:0]   entries [BUF_DEPTH];
    logic [PTR_W-1:0]       head, tail;
    logic [CNT_W-1:0]       count;
    logic [RR_W-1:0]        rr_last, winner;
    logic                   found, grant, push, pop, not_empty;
    logic [PRF_WIDTH-1:0]   head_prf;

    assign not_empty = (count != '0);

    // Head reads as zero whenever nothing valid is buffered or reset is held.
    assign head_prf      = (resetn && not_empty) ? entries[head] : '0;
    assign o_alloc_prf   = head_prf;
    assign o_return_prf  = head_prf;

    assign push = o_fifo_ready && i_fifo_valid;
    assign pop  = grant || (o_return_valid && i_return_ready);

    always_comb begin
        int              idx;
        logic [RR_W-1:0] idx_v;
        found = 1'b0;
        winner = rr_last;
        idx = 0;
        idx_v = '0;
        for (int i = 1; i <= REQ_COUNT; i++) begin
            idx = (int'(rr_last) + i) % REQ_COUNT;
            idx_v = RR_W'(idx);
            if (!found && i_req_valid[idx_v]) begin
                found = 1'b1;
                winner = idx_v;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= RUN;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (i_flush && not_empty) state_next = DRAIN;
            DRAIN:   if (i_return_ready && count == CNT_W'(1)) state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    always_comb begin
        o_fifo_ready   = 1'b0;
        o_return_valid = 1'b0;
        o_busy         = 1'b0;
        o_alloc_valid  = '0;
        grant          = 1'b0;
        if (resetn) begin
            case (state)
                RUN: begin
                    o_fifo_ready = !i_flush && (count != FULL);
                    grant        = !i_flush && not_empty && found;
                    if (grant) o_alloc_valid[winner] = 1'b1;
                end
                DRAIN: begin
                    o_return_valid = 1'b1;
                    o_busy         = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            rr_last <= RR_W'(REQ_COUNT - 1);
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (grant) rr_last <= winner;
        end
    end

    // Storage carries no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (push) entries[tail] <= i_fifo_prf;
    end

endmodule

// File: tb/tb_issue_rat_freelist_alloc_arbiter.sv
// Directed bench for the free-list allocation arbiter with a per-cycle scoreboard
// monitor tracking buffered PRFs, round-robin order and drain behaviour.
module tb_issue_rat_freelist_alloc_arbiter;

    localparam int PRF_WIDTH = 6;
    localparam int REQ_COUNT = 2;
    localparam int BUF_DEPTH = 2;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [REQ_COUNT-1:0] i_req_valid;
    logic [REQ_COUNT-1:0] o_alloc_valid;
    logic [PRF_WIDTH-1:0] o_alloc_prf;
    logic [PRF_WIDTH-1:0] i_fifo_prf;
    logic                 i_fifo_valid;
    logic                 o_fifo_ready;
    logic [PRF_WIDTH-1:0] o_return_prf;
    logic                 o_return_valid;
    logic                 i_return_ready;
    logic                 i_flush;
    logic                 o_busy;

    int compared = 0;
    int mismatched = 0;

    logic [PRF_WIDTH-1:0] sb [$];
    logic                 drain_m = 1'b0;
    int                   rr_m = REQ_COUNT - 1;

    issue_rat_freelist_alloc_arbiter #(
        .PRF_WIDTH(PRF_WIDTH),
        .REQ_COUNT(REQ_COUNT),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .i_req_valid(i_req_valid),
        .o_alloc_valid(o_alloc_valid),
        .o_alloc_prf(o_alloc_prf),
        .i_fifo_prf(i_fifo_prf),
        .i_fifo_valid(i_fifo_valid),
        .o_fifo_ready(o_fifo_ready),
        .o_return_prf(o_return_prf),
        .o_return_valid(o_return_valid),
        .i_return_ready(i_return_ready),
        .i_flush(i_flush),
        .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        i_req_valid = '0;
        i_fifo_valid = 1'b0;
        i_flush = 1'b0;
        i_return_ready = 1'b0;
        next_cycle();
        next_cycle();
        resetn = 1'b1;
    endtask

    // Scoreboard monitor: checks every cycle against a behavioural model.
    always @(negedge clk) begin
        int              sz;
        logic            exp_grant;
        logic            exp_ready;
        logic [REQ_COUNT-1:0] exp_vec;
        int              w;
        int              idx;
        logic            ret_pop;
        sz = sb.size();
        exp_grant = resetn && !drain_m && !i_flush && (sz > 0) && (|i_req_valid);
        exp_vec = '0;
        w = -1;
        if (exp_grant) begin
            for (int i = 1; i <= REQ_COUNT; i++) begin
                idx = (rr_m + i) % REQ_COUNT;
                if (w < 0 && i_req_valid[idx] == 1'b1) w = idx;
            end
            exp_vec[w] = 1'b1;
        end
        check("mon_grant_vec", 32'(o_alloc_valid), 32'(exp_vec));
        if (exp_grant) begin
            check("mon_grant_prf", 32'(o_alloc_prf), 32'(sb[0]));
            void'(sb.pop_front());
            rr_m = w;
        end
        check("mon_busy", 32'(o_busy), 32'(resetn && drain_m));
        check("mon_ret_valid", 32'(o_return_valid), 32'(resetn && drain_m));
        ret_pop = resetn && drain_m && i_return_ready;
        if (resetn && drain_m && sb.size() > 0)
            check("mon_ret_prf", 32'(o_return_prf), 32'(sb[0]));
        if (ret_pop && sb.size() > 0) void'(sb.pop_front());
        exp_ready = resetn && !drain_m && !i_flush && (sz < BUF_DEPTH);
        check("mon_fifo_ready", 32'(o_fifo_ready), 32'(exp_ready));
        if (exp_ready && i_fifo_valid) sb.push_back(i_fifo_prf);
        if (!resetn) begin
            sb.delete();
            drain_m = 1'b0;
            rr_m = REQ_COUNT - 1;
        end else if (!drain_m && i_flush && sz > 0) begin
            drain_m = 1'b1;
        end else if (drain_m && ret_pop && sb.size() == 0) begin
            drain_m = 1'b0;
        end
    end

    initial begin
        resetn = 1'b0;
        i_req_valid = '0;
        i_fifo_prf = '0;
        i_fifo_valid = 1'b0;
        i_return_ready = 1'b0;
        i_flush = 1'b0;
        next_cycle();
        next_cycle();
        mid();
        check("rst_alloc_prf", 32'(o_alloc_prf), 0);
        check("rst_return_prf", 32'(o_return_prf), 0);
        check("rst_fifo_ready", 32'(o_fifo_ready), 0);
        next_cycle();
        resetn = 1'b1;
        mid();
        check("post_rst_fifo_ready", 32'(o_fifo_ready), 1);
        check("post_rst_alloc_prf", 32'(o_alloc_prf), 0);
        next_cycle();

        // Back-to-back supply 5,6,7 with requester 0 held
        i_fifo_valid = 1'b1; i_fifo_prf = 6'd5; i_req_valid = 2'b01;
        mid(); check("t1_c1_grant", 32'(o_alloc_valid), 0);
        next_cycle();
        i_fifo_prf = 6'd6;
        mid(); check("t1_c2_grant", 32'(o_alloc_valid), 32'b01);
        check("t1_c2_prf", 32'(o_alloc_prf), 5);
        next_cycle();
        i_fifo_prf = 6'd7;
        mid(); check("t1_c3_prf", 32'(o_alloc_prf), 6);
        next_cycle();
        i_fifo_valid = 1'b0;
        mid(); check("t1_c4_prf", 32'(o_alloc_prf), 7);
        next_cycle();
        i_req_valid = '0;
        do_reset();

        // Full buffer {9,10}, contended requests
        i_fifo_valid = 1'b1; i_fifo_prf = 6'd9;  next_cycle();
        i_fifo_prf = 6'd10; next_cycle();
        i_fifo_prf = 6'd11;
        mid(); check("t2_full_ready", 32'(o_fifo_ready), 0);
        next_cycle();
        i_fifo_valid = 1'b0; i_req_valid = 2'b11;
        mid(); check("t2_g1_vec", 32'(o_alloc_valid), 32'b01);
        check("t2_g1_prf", 32'(o_alloc_prf), 9);
        next_cycle();
        mid(); check("t2_g2_vec", 32'(o_alloc_valid), 32'b10);
        check("t2_g2_prf", 32'(o_alloc_prf), 10);
        next_cycle();
        i_req_valid = '0; i_fifo_valid = 1'b1; i_fifo_prf = 6'd13;
        next_cycle();
        i_fifo_valid = 1'b0; i_req_valid = 2'b11;
        mid(); check("t2_g3_vec", 32'(o_alloc_valid), 32'b01);
        check("t2_g3_prf", 32'(o_alloc_prf), 13);
        next_cycle();

        // Empty buffer: no bypass from FIFO to grant
        i_req_valid = 2'b10; i_fifo_valid = 1'b1; i_fifo_prf = 6'd12;
        mid(); check("t3_nobypass", 32'(o_alloc_valid), 0);
        next_cycle();
        i_fifo_valid = 1'b0;
        mid(); check("t3_vec", 32'(o_alloc_valid), 32'b10);
        check("t3_prf", 32'(o_alloc_prf), 12);
        next_cycle();
        i_req_valid = '0;

        // Flush with {3,4}, drain with stalled return port
        i_fifo_valid = 1'b1; i_fifo_prf = 6'd3; next_cycle();
        i_fifo_prf = 6'd4; next_cycle();
        i_fifo_valid = 1'b0; i_flush = 1'b1; i_req_valid = 2'b01;
        mid(); check("t4_flush_grant", 32'(o_alloc_valid), 0);
        check("t4_flush_ready", 32'(o_fifo_ready), 0);
        next_cycle();
        i_flush = 1'b0; i_return_ready = 1'b1;
        mid(); check("t4_d1_valid", 32'(o_return_valid), 1);
        check("t4_d1_prf", 32'(o_return_prf), 3);
        check("t4_d1_busy", 32'(o_busy), 1);
        next_cycle();
        i_return_ready = 1'b0; i_flush = 1'b1;
        mid(); check("t4_d2_prf", 32'(o_return_prf), 4);
        check("t4_d2_busy", 32'(o_busy), 1);
        next_cycle();
        i_flush = 1'b0;
        mid(); check("t4_d3_busy", 32'(o_busy), 1);
        next_cycle();
        i_return_ready = 1'b1;
        mid(); check("t4_d4_prf", 32'(o_return_prf), 4);
        next_cycle();
        i_return_ready = 1'b0;
        mid(); check("t4_after_busy", 32'(o_busy), 0);
        check("t4_after_ready", 32'(o_fifo_ready), 1);
        check("t4_after_grant", 32'(o_alloc_valid), 0);
        next_cycle();
        i_req_valid = '0;

        // Steady traffic: push and pop each cycle, pointers wrap
        i_fifo_valid = 1'b1; i_fifo_prf = 6'd19; next_cycle();
        i_req_valid = 2'b01;
        for (int k = 0; k < 10; k++) begin
            i_fifo_prf = 6'(20 + k);
            mid(); check("t5_prf", 32'(o_alloc_prf), 32'(19 + k));
            check("t5_ready", 32'(o_fifo_ready), 1);
            next_cycle();
        end
        i_fifo_valid = 1'b0;
        mid(); check("t5_last_prf", 32'(o_alloc_prf), 29);
        next_cycle();
        i_req_valid = '0;
        mid(); check("t5_empty_prf", 32'(o_alloc_prf), 0);
        next_cycle();

        // Reset while draining two entries
        i_fifo_valid = 1'b1; i_fifo_prf = 6'd30; next_cycle();
        i_fifo_prf = 6'd31; next_cycle();
        i_fifo_valid = 1'b0; i_flush = 1'b1; next_cycle();
        i_flush = 1'b0;
        mid(); check("t6_drain_busy", 32'(o_busy), 1);
        next_cycle();
        resetn = 1'b0;
        mid(); check("t6_rst_busy", 32'(o_busy), 0);
        next_cycle();
        resetn = 1'b1; i_req_valid = 2'b01;
        mid(); check("t6_busy", 32'(o_busy), 0);
        check("t6_ret_valid", 32'(o_return_valid), 0);
        check("t6_grant", 32'(o_alloc_valid), 0);
        check("t6_ready", 32'(o_fifo_ready), 1);
        next_cycle();
        i_req_valid = '0;
        next_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/issue_rat_freelist_alloc_arbiter.md
# issue_rat_freelist_alloc_arbiter

Allocation controller in front of the RAT free-list FIFO. It prefetches free PRF indices from the FIFO acquire port into a small buffer and shares them round-robin among rename-lane requesters at one grant per cycle. On a pipeline flush it returns every buffered, ungranted PRF to the FIFO abandoned port, so no PRF is leaked.

## Interface
- PRF_WIDTH, 6, PRF index width
- REQ_COUNT, 2, number of rename-lane requesters (≥2)
- BUF_DEPTH, 2, prefetch buffer entries (≥2, power of two)

- clk  in  1  clock; all state updates on rising edge
- resetn  in  1  synchronous, active-low reset
- i_req_valid  in  REQ_COUNT  requester k wants one PRF; held high until granted
- o_alloc_valid  out  REQ_COUNT  one-hot grant; requester k consumes o_alloc_prf this cycle
- o_alloc_prf  out  PRF_WIDTH  granted PRF (buffer head)
- i_fifo_prf  in  PRF_WIDTH  free-list acquire data
- i_fifo_valid  in  1  free-list acquire valid
- o_fifo_ready  out  1  acquire ready (pop free list)
- o_return_prf  out  PRF_WIDTH  PRF returned to free list (abandoned port)
- o_return_valid  out  1  return valid
- i_return_ready  in  1  abandoned-port ready
- i_flush  in  1  single-cycle flush pulse
- o_busy  out  1  high while in DRAIN

## Operation
- State register: RUN, DRAIN. Reset → RUN, count=0, head/tail=0, rr_last=REQ_COUNT-1 (requester 0 wins first).
- Buffer: circular, log2(BUF_DEPTH) pointers wrap modulo BUF_DEPTH; count 0..BUF_DEPTH.
- RUN fill: o_fifo_ready = RUN && !i_flush && count<BUF_DEPTH; push on i_fifo_valid && o_fifo_ready.
- RUN grant: if count>0 && !i_flush && any i_req_valid, grant the first valid requester scanning from rr_last+1 modulo REQ_COUNT; pop head; rr_last ← winner. No request or empty buffer: no grant, rr_last unchanged.
- Push and pop in the same cycle: count unchanged; both pointers advance.
- Full buffer: o_fifo_ready=0; FIFO holds data. Empty buffer: no grant, even with requests pending.
- i_flush in RUN: suppresses grant and fill that cycle. Next state is DRAIN if count>0, else RUN. Pending requests are not remembered; requesters re-assert after flush.
- DRAIN: o_return_valid=1, o_return_prf=head; pop on i_return_ready. When the popping entry is the last one (count==1), next state is RUN. o_fifo_ready=0, o_alloc_valid=0, o_busy=1.
- i_flush during DRAIN: ignored.
- Reset mid-operation: buffer contents are discarded. The free-list FIFO shares resetn and reinitialises in the same cycle.

## Timing
- While resetn low, and on the first cycle after release: o_alloc_valid=0, o_return_valid=0, o_busy=0, o_alloc_prf/o_return_prf=0 (buffer head). o_fifo_ready is forced 0 while resetn is low and is 1 from the first cycle after release.
- Grant outputs are combinational from registered buffer head, count and rr_last, plus i_req_valid and i_flush. Zero-cycle request-to-grant when count>0.
- No bypass: a PRF accepted from the FIFO at edge N is grantable from cycle N+1.
- Sustained throughput: 1 grant/cycle with continuous i_fifo_valid and BUF_DEPTH≥2.
- Flush at edge N with count=c>0: DRAIN cycles N+1..; exactly c returns, one per cycle with i_return_ready=1. RUN and o_fifo_ready=1 in the cycle after the last return.
- No combinational path from i_fifo_valid or i_return_ready to any output.

## Test plan
- Reset, FIFO supplies 5,6,7 back-to-back, req0 held high → o_alloc_valid=01 with PRF 5 on cycle 2, then 6, then 7 on consecutive cycles; o_fifo_ready=0 whenever count==2.
- Buffer full {9,10}, req0 and req1 both high for 2 cycles → grants req0:9, then req1:10; rr_last=1. Next contended cycle grants req0.
- Buffer empty, req1 high, FIFO valid PRF 12 at edge N → no grant in cycle N; grant req1:12 in cycle N+1.
- Buffer {3,4}, i_flush with req0 high → no grant that cycle. DRAIN returns 3 then 4 (i_return_ready stalls 2 cycles before 4); o_busy high throughout; RUN afterwards, no PRF granted.
- Simultaneous push of 20 and grant of head 19 with count=1 → count stays 1, head=20; pointers wrap correctly over 10 cycles of steady traffic.
- resetn low during DRAIN with count=2 → next cycle RUN, count=0, all valids 0, o_busy=0.
